// File: rtl/lcd_responder.sv
// lcd_responder: display-side HD44780-style 8-bit bus responder with a 2x16 DDRAM and scanner port.
// Define LCD_RESP_BUSY_EN to model per-command execution time on the busy flag.
module lcd_responder #(
    parameter int unsigned CMD_CYCLES   = 40,
    parameter int unsigned CLEAR_CYCLES = 1640
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic [4:0] cursor_pos,
    output logic [3:0] disp_shift,
    output logic       busy
);

`ifdef LCD_RESP_BUSY_EN
    localparam int unsigned MaxCycles = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    typedef enum logic [1:0] {StClear, StIdle, StBusy} state_e;
    logic [CntW-1:0] cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {StClear, StIdle} state_e;
`endif

    state_e      state_q, state_d;
    logic [10:0] sync1_q, sync2_q;
    logic        en_prev_q;
    logic [4:0]  clr_idx_q, clr_idx_d;
    logic [4:0]  ac_q, ac_d;
    logic [3:0]  shift_q, shift_d;
    logic        id_q, id_d, s_q, s_d;
    logic        d_q, d_d, c_q, c_d, b_q, b_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  ddram_q [32];

    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic        rs_s, rw_s, en_s, strobe;
    logic [7:0]  db_s;
    logic [3:0]  scan_col;

    assign {rs_s, rw_s, en_s, db_s} = sync2_q;
    assign strobe = en_prev_q & ~en_s;

    assign busy         = (state_q != StIdle);
    assign lcd_data_oe  = en_s & rw_s;
    assign lcd_data_out = dout_q;
    assign disp_on      = d_q;
    assign cursor_on    = c_q;
    assign blink_on     = b_q;
    assign cursor_pos   = ac_q;
    assign disp_shift   = shift_q;

    assign scan_col = rd_addr[3:0] + shift_q;
    assign rd_char  = ddram_q[{rd_addr[4], scan_col}];

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ac_d      = ac_q;
        shift_d   = shift_q;
        id_d      = id_q;
        s_d       = s_q;
        d_d       = d_q;
        c_d       = c_q;
        b_d       = b_q;
        dout_d    = dout_q;
        mem_we    = 1'b0;
        mem_waddr = ac_q;
        mem_wdata = db_s;
`ifdef LCD_RESP_BUSY_EN
        cnt_d     = cnt_q;
`endif

        if (en_s && rw_s) begin
            dout_d = rs_s ? ddram_q[ac_q] : {busy, 1'b0, ac_q[4], 1'b0, ac_q[3:0]};
        end

        case (state_q)
            StClear: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                mem_wdata = 8'h20;
                clr_idx_d = clr_idx_q + 5'd1;
                if (clr_idx_q == 5'd31) begin
`ifdef LCD_RESP_BUSY_EN
                    state_d = StBusy;
                    cnt_d   = CntW'(CLEAR_CYCLES - 1);
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef LCD_RESP_BUSY_EN
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
`endif
            default: ;
        endcase

        if (strobe) begin
            if (rw_s) begin
                // Data reads advance AC only when the controller is not busy.
                if (rs_s && !busy) begin
                    ac_d = ac_q + (id_q ? 5'd1 : 5'd31);
                end
            end else if (!busy) begin
`ifdef LCD_RESP_BUSY_EN
                state_d = StBusy;
                cnt_d   = CntW'(CMD_CYCLES - 1);
`endif
                if (rs_s) begin
                    mem_we = 1'b1;
                    ac_d   = ac_q + (id_q ? 5'd1 : 5'd31);
                    if (s_q) begin
                        shift_d = shift_q + (id_q ? 4'd1 : 4'd15);
                    end
                end else if (db_s[7]) begin
                    ac_d = {db_s[6], db_s[3:0]};
                end else if (db_s[6] || db_s[5]) begin
                    // CGRAM address and function set have no visible effect here.
                end else if (db_s[4]) begin
                    if (db_s[3]) begin
                        shift_d = shift_q + (db_s[2] ? 4'd1 : 4'd15);
                    end else begin
                        ac_d = ac_q + (db_s[2] ? 5'd1 : 5'd31);
                    end
                end else if (db_s[3]) begin
                    d_d = db_s[2];
                    c_d = db_s[1];
                    b_d = db_s[0];
                end else if (db_s[2]) begin
                    id_d = db_s[1];
                    s_d  = db_s[0];
                end else if (db_s[1]) begin
                    ac_d    = '0;
                    shift_d = '0;
`ifdef LCD_RESP_BUSY_EN
                    cnt_d   = CntW'(CLEAR_CYCLES - 1);
`endif
                end else if (db_s[0]) begin
                    state_d   = StClear;
                    clr_idx_d = '0;
                    ac_d      = '0;
                    shift_d   = '0;
                    id_d      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            en_prev_q <= 1'b0;
            state_q   <= StClear;
            clr_idx_q <= '0;
            ac_q      <= '0;
            shift_q   <= '0;
            id_q      <= 1'b1;
            s_q       <= 1'b0;
            d_q       <= 1'b0;
            c_q       <= 1'b0;
            b_q       <= 1'b0;
            dout_q    <= '0;
`ifdef LCD_RESP_BUSY_EN
            cnt_q     <= '0;
`endif
        end else begin
            sync1_q   <= {lcd_rs, lcd_rw, lcd_en, lcd_data_in};
            sync2_q   <= sync1_q;
            en_prev_q <= en_s;
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ac_q      <= ac_d;
            shift_q   <= shift_d;
            id_q      <= id_d;
            s_q       <= s_d;
            d_q       <= d_d;
            c_q       <= c_d;
            b_q       <= b_d;
            dout_q    <= dout_d;
`ifdef LCD_RESP_BUSY_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // DDRAM contents are defined by the CLEAR sweep that follows every reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            ddram_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_lcd_responder.sv
// tb_lcd_responder: table-driven, directed and randomized checks of lcd_responder
// against a behavioural model of the display controller.
module tb_lcd_responder;
    localparam int CmdCycles   = 40;
    localparam int ClearCycles = 1640;
`ifdef LCD_RESP_BUSY_EN
    localparam bit BusyEn = 1'b1;
`else
    localparam bit BusyEn = 1'b0;
`endif
    localparam int CmdBusy = BusyEn ? CmdCycles : 0;
    localparam int ClrBusy = BusyEn ? ClearCycles : 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
    logic [7:0] lcd_data_in = 8'h00;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char;
    logic       disp_on, cursor_on, blink_on;
    logic [4:0] cursor_pos;
    logic [3:0] disp_shift;
    logic       busy;

    lcd_responder #(
        .CMD_CYCLES  (CmdCycles),
        .CLEAR_CYCLES(ClearCycles)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_en      (lcd_en),
        .lcd_data_in (lcd_data_in),
        .lcd_data_out(lcd_data_out),
        .lcd_data_oe (lcd_data_oe),
        .rd_addr     (rd_addr),
        .rd_char     (rd_char),
        .disp_on     (disp_on),
        .cursor_on   (cursor_on),
        .blink_on    (blink_on),
        .cursor_pos  (cursor_pos),
        .disp_shift  (disp_shift),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model of the display state.
    logic [7:0] m_mem [32];
    int m_ac, m_shift;
    bit m_id, m_s, m_d, m_c, m_b;
    int busy_until, clr_until;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit         rs;
        logic [7:0] db;
        logic [4:0] addr;
        logic [7:0] ch;
        logic [4:0] pos;
        logic [3:0] sh;
        logic [2:0] dcb;
    } vec_t;
    vec_t tbl [20];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] m_char(input logic [4:0] a);
        int col;
        col = (int'(a[3:0]) + m_shift) % 16;
        return m_mem[(a[4] ? 16 : 0) + col];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_ac = 0; m_shift = 0; m_id = 1'b1; m_s = 1'b0;
        m_d = 1'b0; m_c = 1'b0; m_b = 1'b0;
    endtask

    // Apply the effect of a strobe whose state update lands on edge e.
    task automatic model_strobe(input bit rs, input bit rw, input logic [7:0] db, input int e);
        bit was_busy;
        int v;
        was_busy = (e - 1) < busy_until;
        v = int'(db);
        if (rw) begin
            if (rs && !was_busy) m_ac = (m_ac + (m_id ? 1 : 31)) % 32;
        end else if (!was_busy) begin
            busy_until = e + CmdBusy;
            if (rs) begin
                m_mem[m_ac] = db;
                if (m_s) m_shift = (m_shift + (m_id ? 1 : 15)) % 16;
                m_ac = (m_ac + (m_id ? 1 : 31)) % 32;
            end else if (v == 1) begin
                for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
                m_ac = 0; m_shift = 0; m_id = 1'b1;
                clr_until  = e + 32;
                busy_until = e + 32 + ClrBusy;
            end else if (v == 2 || v == 3) begin
                m_ac = 0; m_shift = 0;
                busy_until = e + ClrBusy;
            end else if (v >= 4 && v < 8) begin
                m_id = db[1]; m_s = db[0];
            end else if (v >= 8 && v < 16) begin
                m_d = db[2]; m_c = db[1]; m_b = db[0];
            end else if (v >= 16 && v < 32) begin
                if (db[3]) m_shift = (m_shift + (db[2] ? 1 : 15)) % 16;
                else m_ac = (m_ac + (db[2] ? 1 : 31)) % 32;
            end else if (v >= 128) begin
                m_ac = (db[6] ? 16 : 0) + (v % 16);
            end
        end
    endtask

    task automatic bus_write(input bit rs, input logic [7:0] db);
        int e;
        lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = db; lcd_en = 1'b1;
        tick(); tick();
        lcd_en = 1'b0;
        e = cyc + 3;
        tick(); tick();
        check("pre_strobe_pos", int'(cursor_pos), m_ac);
        check("pre_strobe_busy", int'(busy), int'((e - 1) < busy_until));
        tick();
        model_strobe(rs, 1'b0, db, e);
        check("post_strobe_busy", int'(busy), int'(cyc < busy_until));
    endtask

    task automatic bus_read(input bit rs, output logic [7:0] got);
        int e, s;
        logic [4:0] a5;
        logic [7:0] exp;
        lcd_rs = rs; lcd_rw = 1'b1; lcd_data_in = 8'h00; lcd_en = 1'b1;
        tick();
        check("oe_early", int'(lcd_data_oe), 0);
        tick();
        check("oe_rise", int'(lcd_data_oe), 1);
        tick();
        s   = cyc;
        a5  = 5'(m_ac);
        exp = rs ? m_mem[m_ac] : {((s - 1) < busy_until), 1'b0, a5[4], 1'b0, a5[3:0]};
        got = lcd_data_out;
        if (!rs || (s - 1) >= clr_until) check("read_data", int'(lcd_data_out), int'(exp));
        tick();
        lcd_en = 1'b0;
        e = cyc + 3;
        tick();
        check("oe_hold", int'(lcd_data_oe), 1);
        tick();
        check("oe_fall", int'(lcd_data_oe), 0);
        tick();
        model_strobe(rs, 1'b1, 8'h00, e);
        lcd_rw = 1'b0;
    endtask

    task automatic wait_idle();
        if (cyc < busy_until) begin
            while (cyc < busy_until - 1) tick();
            check("busy_last_cycle", int'(busy), 1);
            tick();
        end
        check("busy_drop", int'(busy), 0);
    endtask

    task automatic check_state();
        logic [4:0] a;
        a = 5'($urandom);
        check("cursor_pos", int'(cursor_pos), m_ac);
        check("disp_shift", int'(disp_shift), m_shift);
        check("dcb_flags", int'({disp_on, cursor_on, blink_on}), int'({m_d, m_c, m_b}));
        rd_addr = a;
        #1;
        if (cyc >= clr_until) check("rd_char", int'(rd_char), int'(m_char(a)));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; lcd_en = 1'b0; lcd_rw = 1'b0; lcd_rs = 1'b0;
        #1;
        check("rst_busy", int'(busy), 1);
        check("rst_oe", int'(lcd_data_oe), 0);
        check("rst_dout", int'(lcd_data_out), 0);
        check("rst_flags", int'({disp_on, cursor_on, blink_on}), 0);
        check("rst_pos", int'(cursor_pos), 0);
        check("rst_shift", int'(disp_shift), 0);
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
        clr_until  = cyc + 32;
        busy_until = cyc + 32 + ClrBusy;
    endtask

    task automatic check_all_blank(input string name);
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            #1;
            check(name, int'(rd_char), 8'h20);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        logic [7:0] cmd;
        int kind;

        tbl[0]  = '{1'b0, 8'h38, 5'd0,  8'h20, 5'd0,  4'd0, 3'b000};
        tbl[1]  = '{1'b0, 8'h0E, 5'd0,  8'h20, 5'd0,  4'd0, 3'b110};
        tbl[2]  = '{1'b0, 8'h06, 5'd1,  8'h20, 5'd0,  4'd0, 3'b110};
        tbl[3]  = '{1'b1, 8'h41, 5'd0,  8'h41, 5'd1,  4'd0, 3'b110};
        tbl[4]  = '{1'b1, 8'h42, 5'd1,  8'h42, 5'd2,  4'd0, 3'b110};
        tbl[5]  = '{1'b0, 8'h8F, 5'd1,  8'h42, 5'd15, 4'd0, 3'b110};
        tbl[6]  = '{1'b1, 8'h58, 5'd15, 8'h58, 5'd16, 4'd0, 3'b110};
        tbl[7]  = '{1'b1, 8'h59, 5'd16, 8'h59, 5'd17, 4'd0, 3'b110};
        tbl[8]  = '{1'b0, 8'h1C, 5'd15, 8'h41, 5'd17, 4'd1, 3'b110};
        tbl[9]  = '{1'b0, 8'h1C, 5'd14, 8'h41, 5'd17, 4'd2, 3'b110};
        tbl[10] = '{1'b0, 8'h02, 5'd16, 8'h59, 5'd0,  4'd0, 3'b110};
        tbl[11] = '{1'b0, 8'h10, 5'd15, 8'h58, 5'd31, 4'd0, 3'b110};
        tbl[12] = '{1'b0, 8'h14, 5'd0,  8'h41, 5'd0,  4'd0, 3'b110};
        tbl[13] = '{1'b0, 8'h04, 5'd0,  8'h41, 5'd0,  4'd0, 3'b110};
        tbl[14] = '{1'b1, 8'h5A, 5'd0,  8'h5A, 5'd31, 4'd0, 3'b110};
        tbl[15] = '{1'b0, 8'h07, 5'd1,  8'h42, 5'd31, 4'd0, 3'b110};
        tbl[16] = '{1'b1, 8'h61, 5'd30, 8'h61, 5'd0,  4'd1, 3'b110};
        tbl[17] = '{1'b0, 8'h0D, 5'd14, 8'h58, 5'd0,  4'd1, 3'b101};
        tbl[18] = '{1'b0, 8'h18, 5'd0,  8'h5A, 5'd0,  4'd0, 3'b101};
        tbl[19] = '{1'b0, 8'h06, 5'd31, 8'h61, 5'd0,  4'd0, 3'b101};

        busy_until = 0;
        clr_until  = 0;
        tick();
        do_reset();

        // Busy flag reads during the power-on clear and once idle.
        bus_read(1'b0, got);
        check("busy_read_clearing", int'(got), 8'h80);
        wait_idle();
        bus_read(1'b0, got);
        check("busy_read_idle", int'(got), 8'h00);
        check_all_blank("blank_after_reset");

        for (int i = 0; i < 20; i++) begin
            wait_idle();
            bus_write(tbl[i].rs, tbl[i].db);
            wait_idle();
            check("tbl_pos", int'(cursor_pos), int'(tbl[i].pos));
            check("tbl_shift", int'(disp_shift), int'(tbl[i].sh));
            check("tbl_dcb", int'({disp_on, cursor_on, blink_on}), int'(tbl[i].dcb));
            rd_addr = tbl[i].addr;
            #1;
            check("tbl_rd_char", int'(rd_char), int'(tbl[i].ch));
        end

        // Data write issued 10 cycles after a command.
        wait_idle();
        bus_write(1'b0, 8'h80);
        repeat (5) tick();
        bus_write(1'b1, 8'h77);
        bus_read(1'b0, got);
        check("busy_read_db7", int'(got[7]), int'(BusyEn));
        wait_idle();
        check_state();
        rd_addr = 5'd0;
        #1;
        check("drop_mem0", int'(rd_char), BusyEn ? 8'h5A : 8'h77);
        check("drop_ac", int'(cursor_pos), BusyEn ? 0 : 1);

        // Data read advances AC.
        wait_idle();
        bus_write(1'b0, 8'hC3);
        wait_idle();
        bus_write(1'b1, 8'h33);
        wait_idle();
        bus_write(1'b0, 8'hC3);
        wait_idle();
        bus_read(1'b1, got);
        check("data_read_c3", int'(got), 8'h33);
        wait_idle();
        check("data_read_ac", int'(cursor_pos), 20);

        // Clear strobe issued while a command executes.
        bus_write(1'b0, 8'h0C);
        repeat (5) tick();
        bus_write(1'b0, 8'h01);
        wait_idle();
        check_state();
        check("clear_mid_op_pos", int'(cursor_pos), BusyEn ? 20 : 0);
        bus_write(1'b0, 8'h01);
        wait_idle();
        check_all_blank("blank_after_clear");

        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 99));
            if ($urandom_range(0, 4) != 0) wait_idle();
            if (kind < 40) begin
                bus_write(1'b1, 8'($urandom));
            end else if (kind < 48) begin
                bus_read(1'b1, got);
            end else if (kind < 56) begin
                bus_read(1'b0, got);
            end else if (kind < 60) begin
                bus_write(1'b0, 8'($urandom_range(1, 3)));
            end else begin
                if ($urandom_range(0, 1) != 0) cmd = 8'($urandom_range(4, 31));
                else cmd = 8'($urandom_range(32, 255));
                bus_write(1'b0, cmd);
            end
            check_state();
        end

        // Asynchronous reset while a command is executing.
        wait_idle();
        bus_write(1'b0, 8'h0F);
        repeat (3) tick();
        do_reset();
        wait_idle();
        check_all_blank("blank_after_mid_reset");
        check_state();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
